// File: rtl/noc_lsu_readreq_tx_pkg.sv
// noc_lsu_readreq_tx_pkg: shared NoC header field positions, LSU message codes and read-request FSM states.
package noc_lsu_readreq_tx_pkg;
  localparam int NOC_FLIT_W = 32;
  localparam int NOC_ID_W = 5;
  localparam int NOC_MAX_LEN = 32;
  localparam int NOC_DEST_MSB = 31;
  localparam int NOC_DEST_LSB = 27;
  localparam int NOC_CLASS_MSB = 26;
  localparam int NOC_CLASS_LSB = 24;
  localparam int NOC_SRC_MSB = 23;
  localparam int NOC_SRC_LSB = 19;
  localparam int NOC_MSG_MSB = 18;
  localparam int NOC_MSG_LSB = 16;
  localparam int NOC_SIZE_BIT = 15;
  localparam logic [2:0] NOC_CLASS_LSU = 3'h2;
  localparam logic [2:0] NOC_LSU_READREQ = 3'h0;
  localparam int NOC_LSU_LEN_MSB = 4;
  localparam int NOC_LSU_LEN_LSB = 0;
  localparam int NOC_LSU_LEN_W = NOC_LSU_LEN_MSB - NOC_LSU_LEN_LSB + 1;
  localparam int NOC_LSU_MAX_BURST = NOC_MAX_LEN - 1;
  typedef enum logic [1:0] {IDLE, HDR, ADDR, LEN} lsu_rdreq_state_t;
  function automatic logic [NOC_FLIT_W-1:0] lsu_readreq_hdr(input logic [NOC_ID_W-1:0] dest,
                                                            input logic [NOC_ID_W-1:0] src,
                                                            input logic size);
    logic [NOC_FLIT_W-1:0] h;
    h = '0;
    h[NOC_DEST_MSB:NOC_DEST_LSB] = dest;
    h[NOC_CLASS_MSB:NOC_CLASS_LSB] = NOC_CLASS_LSU;
    h[NOC_SRC_MSB:NOC_SRC_LSB] = src;
    h[NOC_MSG_MSB:NOC_MSG_LSB] = NOC_LSU_READREQ;
    h[NOC_SIZE_BIT] = size;
    return h;
  endfunction
  function automatic logic [NOC_FLIT_W-1:0] lsu_len_flit(input logic [NOC_LSU_LEN_W-1:0] len);
    logic [NOC_FLIT_W-1:0] f;
    f = '0;
    f[NOC_LSU_LEN_MSB:NOC_LSU_LEN_LSB] = len;
    return f;
  endfunction
endpackage

// File: rtl/noc_lsu_readreq_tx_if.sv
// noc_lsu_readreq_tx_if: request handshake and NoC output flit port of the LSU read-request transmitter.
interface noc_lsu_readreq_tx_if;
  import noc_lsu_readreq_tx_pkg::*;
  logic req_valid, req_ready, req_burst;
  logic [NOC_ID_W-1:0] req_dest;
  logic [NOC_FLIT_W-1:0] req_addr;
  logic [NOC_LSU_LEN_W-1:0] req_len;
  logic [NOC_FLIT_W-1:0] noc_out_flit;
  logic noc_out_last, noc_out_valid, noc_out_ready;
  modport master(output req_valid, req_dest, req_addr, req_burst, req_len, noc_out_ready,
                 input req_ready, noc_out_flit, noc_out_last, noc_out_valid);
  modport slave(input req_valid, req_dest, req_addr, req_burst, req_len, noc_out_ready,
                output req_ready, noc_out_flit, noc_out_last, noc_out_valid);
endinterface

// File: rtl/noc_lsu_readreq_tx_outstanding_ctr.sv
// noc_lsu_outstanding_ctr: saturating outstanding-read counter with limit compare and sticky underflow flag.
module noc_lsu_outstanding_ctr #(
  parameter int MAX = 4,
  parameter int CNTW = $clog2(MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            full,
  output logic            err_underflow
);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_comb begin
    cnt_d = (inc && !dec && cnt_q != CNTW'(MAX)) ? cnt_q + CNTW'(1) :
            (dec && !inc && cnt_q != '0)         ? cnt_q - CNTW'(1) : cnt_q;
    err_d = err_q | (dec && cnt_q == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign cnt = cnt_q;
  assign full = cnt_q >= CNTW'(MAX);
  assign err_underflow = err_q;
endmodule

// File: rtl/noc_lsu_readreq_tx.sv
// noc_lsu_readreq_tx: builds LSU read-request packets flit by flit; NOC_LSU_BURST_EN enables 3-flit burst packets.
module noc_lsu_readreq_tx
  import noc_lsu_readreq_tx_pkg::*;
#(
  parameter int SRC_ID = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNTW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_lsu_readreq_tx_if.slave   bus,
  input  logic                  resp_done,
  output logic [CNTW-1:0]       outstanding,
  output logic                  err_underflow
);
  lsu_rdreq_state_t state_q, state_d;
  logic [NOC_FLIT_W-1:0] addr_q, addr_d, flit_q, flit_d;
  logic last_q, last_d, valid_q, valid_d;
  logic full, accept, fire, size_in;
`ifdef NOC_LSU_BURST_EN
  logic size_q, size_d;
  logic [NOC_LSU_LEN_W-1:0] len_q, len_d;
  assign size_in = bus.req_burst && bus.req_len >= NOC_LSU_LEN_W'(2);
`else
  assign size_in = 1'b0;
`endif
  assign bus.req_ready = state_q == IDLE && !full;
  assign accept = bus.req_valid && bus.req_ready;
  assign fire = valid_q && bus.noc_out_ready;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    flit_d = flit_q;
    last_d = last_q;
    valid_d = valid_q;
`ifdef NOC_LSU_BURST_EN
    size_d = size_q;
    len_d = len_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d = HDR;
        addr_d = bus.req_addr;
        flit_d = lsu_readreq_hdr(bus.req_dest, NOC_ID_W'(SRC_ID), size_in);
        last_d = 1'b0;
        valid_d = 1'b1;
`ifdef NOC_LSU_BURST_EN
        size_d = size_in;
        len_d = bus.req_len;
`endif
      end
      HDR: if (fire) begin
        state_d = ADDR;
        flit_d = addr_q;
`ifdef NOC_LSU_BURST_EN
        last_d = !size_q;
`else
        last_d = 1'b1;
`endif
      end
      ADDR: if (fire) begin
`ifdef NOC_LSU_BURST_EN
        if (size_q) begin
          state_d = LEN;
          flit_d = lsu_len_flit(len_q);
          last_d = 1'b1;
        end else
`endif
        begin
          state_d = IDLE;
          flit_d = '0;
          last_d = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: if (fire) begin
        state_d = IDLE;
        flit_d = '0;
        last_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      flit_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef NOC_LSU_BURST_EN
      size_q <= 1'b0;
      len_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      flit_q <= flit_d;
      last_q <= last_d;
      valid_q <= valid_d;
`ifdef NOC_LSU_BURST_EN
      size_q <= size_d;
      len_q <= len_d;
`endif
    end
  end
  assign bus.noc_out_flit = flit_q;
  assign bus.noc_out_last = last_q;
  assign bus.noc_out_valid = valid_q;
  noc_lsu_outstanding_ctr #(.MAX(MAX_OUTSTANDING), .CNTW(CNTW)) u_ctr (
    .clk(clk),
    .rst(rst),
    .inc(accept),
    .dec(resp_done),
    .cnt(outstanding),
    .full(full),
    .err_underflow(err_underflow)
  );
endmodule

// File: tb/tb_noc_lsu_readreq_tx.sv
// tb_noc_lsu_readreq_tx: scoreboard bench with directed and random read requests against a packet-level model.
module tb_noc_lsu_readreq_tx;
  localparam int MAXO = 4;
  localparam int SRC = 1;
`ifdef NOC_LSU_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  typedef struct packed {logic [31:0] flit; logic last;} flit_t;
  logic clk = 1'b0, rst = 1'b1, resp_done = 1'b0;
  logic [2:0] outstanding;
  logic err_underflow;
  flit_t sb[$];
  int errs = 0, checks = 0, m_cnt = 0;
  bit m_err = 1'b0, accepted = 1'b0, pstall = 1'b0, plast;
  logic [31:0] pflit;
  noc_lsu_readreq_tx_if bus();
  noc_lsu_readreq_tx #(.SRC_ID(SRC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .resp_done(resp_done),
    .outstanding(outstanding),
    .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void push_pkt(logic [4:0] d, logic [31:0] a, logic b, logic [4:0] l);
    logic [4:0] src;
    logic size;
    src = 5'(SRC);
    size = BURST && b && l >= 5'd2;
    sb.push_back('{{d, 3'h2, src, 3'h0, size, 15'h0}, 1'b0});
    sb.push_back('{a, !size});
    if (size) sb.push_back('{{27'h0, l}, 1'b1});
  endfunction
  task automatic step();
    @(negedge clk);
    accepted = !rst && bus.req_valid && bus.req_ready;
    if (accepted) push_pkt(bus.req_dest, bus.req_addr, bus.req_burst, bus.req_len);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [4:0] d, input logic [31:0] a, input logic b, input logic [4:0] l, input logic done);
    bus.req_valid = 1'b1;
    bus.req_dest = d;
    bus.req_addr = a;
    bus.req_burst = b;
    bus.req_len = l;
    resp_done = done;
    for (int i = 0; i < 60; i++) begin
      step();
      resp_done = 1'b0;
      if (accepted) break;
    end
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) step();
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask
  task automatic done_pulse();
    resp_done = 1'b1;
    step();
    resp_done = 1'b0;
  endtask
  initial begin
    flit_t e;
    bit acc;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        sb.delete();
        m_cnt = 0;
        m_err = 1'b0;
        pstall = 1'b0;
      end else begin
        chk("req_ready", bus.req_ready, sb.size() == 0 && m_cnt < MAXO);
        chk("outstanding", outstanding, m_cnt);
        chk("err_underflow", err_underflow, m_err);
        chk("noc_out_valid", bus.noc_out_valid, sb.size() != 0);
        if (pstall) begin
          chk("hold_flit", bus.noc_out_flit, pflit);
          chk("hold_last", bus.noc_out_last, plast);
        end
        if (bus.noc_out_valid && bus.noc_out_ready) begin
          if (sb.size() == 0) chk("unexpected_flit", bus.noc_out_flit, 32'hx);
          else begin
            e = sb.pop_front();
            chk("flit", bus.noc_out_flit, e.flit);
            chk("last", bus.noc_out_last, e.last);
          end
        end
        pstall = bus.noc_out_valid && !bus.noc_out_ready;
        pflit = bus.noc_out_flit;
        plast = bus.noc_out_last;
        acc = bus.req_valid && bus.req_ready;
        if (resp_done && m_cnt == 0) m_err = 1'b1;
        if (acc && !resp_done && m_cnt < MAXO) m_cnt++;
        else if (resp_done && !acc && m_cnt > 0) m_cnt--;
      end
    end
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_dest = '0;
    bus.req_addr = '0;
    bus.req_burst = 1'b0;
    bus.req_len = '0;
    bus.noc_out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_flit", bus.noc_out_flit, 32'h0);
    chk("rst_last", bus.noc_out_last, 32'h0);
    send(5'd3, 32'h0000_1000, 1'b0, 5'd0, 1'b0);
    drain();
    send(5'd3, 32'h0000_2000, 1'b1, 5'd8, 1'b0);
    drain();
    send(5'd3, 32'h0000_3000, 1'b1, 5'd1, 1'b0);
    drain();
    repeat (3) done_pulse();
    send(5'd7, 32'h0000_4000, 1'b0, 5'd0, 1'b0);
    step();
    bus.noc_out_ready = 1'b0;
    repeat (5) step();
    bus.noc_out_ready = 1'b1;
    drain();
    send(5'd9, 32'h0000_5000, 1'b1, 5'd4, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      send(5'(i), 32'h100 * i, 1'b0, 5'd0, 1'b0);
      drain();
    end
    repeat (3) step();
    done_pulse();
    send(5'd2, 32'hABCD_0000, 1'b0, 5'd0, 1'b1);
    drain();
    repeat (6) done_pulse();
    repeat (2) step();
    done_pulse();
    for (int i = 0; i < 600; i++) begin
      bus.noc_out_ready = $urandom_range(0, 3) != 0;
      resp_done = $urandom_range(0, 6) == 0;
      rst = $urandom_range(0, 199) == 0;
      if (!bus.req_valid || accepted) begin
        bus.req_valid = $urandom_range(0, 1) == 1;
        bus.req_dest = 5'($urandom);
        bus.req_addr = $urandom;
        bus.req_burst = $urandom_range(0, 1) == 1;
        bus.req_len = 5'($urandom_range(0, 31));
      end
      step();
    end
    rst = 1'b0;
    resp_done = 1'b0;
    bus.req_valid = 1'b0;
    bus.noc_out_ready = 1'b1;
    drain();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
